// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-master memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TURN = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    MASTER_INSTR = 2'd0,
    MASTER_DATA  = 2'd1,
    MASTER_DMA   = 2'd2
  } master_t;

  localparam logic [15:0] TIMEOUT_DATA = 16'hffff;

  typedef struct packed {
    logic [18:0] addr;
    logic [15:0] wdata;
    logic        wr_en;
    logic [1:0]  bytesel;
  } bus_req_t;

  // Rotation order instr -> data -> dma -> instr.
  function automatic master_t next_master(input master_t m);
    case (m)
      MASTER_INSTR: return MASTER_DATA;
      MASTER_DATA:  return MASTER_DMA;
      default:      return MASTER_INSTR;
    endcase
  endfunction

  function automatic master_t grant_owner(input logic [2:0] grant);
    if (grant[1]) return MASTER_DATA;
    if (grant[2]) return MASTER_DMA;
    return MASTER_INSTR;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first requester at or after the pointer.
module rr_priority_pick
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  master_t    ptr,
  output logic [2:0] grant
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant = '0;
    case (ptr)
      MASTER_DATA: begin
        if      (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      MASTER_DMA: begin
        if      (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if      (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/rr_mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between the CPU instruction port,
// the CPU data port and a DMA/debug master, with optional slave timeout.
module rr_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_in,
  input  logic [18:0] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_in,
  input  logic [18:0] dma_m_addr,
  input  logic [15:0] dma_m_data_out,
  input  logic        dma_m_access,
  input  logic        dma_m_wr_en,
  input  logic [1:0]  dma_m_bytesel,
  output logic        dma_m_ack,
  output logic [15:0] dma_m_data_in,
  output logic [18:0] q_m_addr,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  input  logic [15:0] q_m_data_in,
  input  logic        q_m_ack,
  output logic        bus_error
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  master_t          ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]  pick_grant;
  logic        busy;
  logic        timeout_hit;
  logic        done;
  logic [2:0]  ack_vec;
  logic [15:0] rdata;
  bus_req_t    sel;

  rr_priority_pick u_pick (
    .req   ({dma_m_access, data_m_access, instr_m_access}),
    .ptr   (ptr_q),
    .grant (pick_grant)
  );

  assign busy        = (state_q == ST_BUSY);
  // A real ack in the timeout cycle wins, so the forced completion requires !q_m_ack.
  assign timeout_hit = TIMEOUT_EN && busy && (cnt_q == CNT_LAST) && !q_m_ack;
  assign done        = busy && (q_m_ack || timeout_hit);
  assign ack_vec     = done ? grant_q : 3'b000;
  assign rdata       = q_m_ack ? q_m_data_in : TIMEOUT_DATA;

  // grant_q is non-zero only in BUSY, so the bus idles at zero otherwise.
  always_comb begin
    sel = '0;
    if (grant_q[0]) begin
      sel.addr    = instr_m_addr;
      sel.bytesel = 2'b11;
    end else if (grant_q[1]) begin
      sel.addr    = data_m_addr;
      sel.wdata   = data_m_data_out;
      sel.wr_en   = data_m_wr_en;
      sel.bytesel = data_m_bytesel;
    end else if (grant_q[2]) begin
      sel.addr    = dma_m_addr;
      sel.wdata   = dma_m_data_out;
      sel.wr_en   = dma_m_wr_en;
      sel.bytesel = dma_m_bytesel;
    end
  end

  assign q_m_access   = busy;
  assign q_m_addr     = sel.addr;
  assign q_m_data_out = sel.wdata;
  assign q_m_wr_en    = sel.wr_en;
  assign q_m_bytesel  = sel.bytesel;
  assign bus_error    = timeout_hit;

  assign instr_m_ack     = ack_vec[0];
  assign data_m_ack      = ack_vec[1];
  assign dma_m_ack       = ack_vec[2];
  assign instr_m_data_in = ack_vec[0] ? rdata : 16'h0000;
  assign data_m_data_in  = ack_vec[1] ? rdata : 16'h0000;
  assign dma_m_data_in   = ack_vec[2] ? rdata : 16'h0000;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|pick_grant) begin
          grant_d = pick_grant;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (done) begin
          grant_d = '0;
          ptr_d   = next_master(grant_owner(grant_q));
          state_d = ST_TURN;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_TURN: state_d = ST_IDLE;
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= MASTER_INSTR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Directed bench for rr_mem_arbiter: a transaction-level model checks every cycle,
// directed sequences add hand-computed expectations.
module tb_rr_mem_arbiter;

  localparam int TO_MAIN = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [18:0] instr_m_addr, data_m_addr, dma_m_addr;
  logic        instr_m_access, data_m_access, dma_m_access;
  logic [15:0] data_m_data_out, dma_m_data_out, q_m_data_in;
  logic        data_m_wr_en, dma_m_wr_en, q_m_ack;
  logic [1:0]  data_m_bytesel, dma_m_bytesel;

  logic        instr_m_ack, data_m_ack, dma_m_ack, q_m_access, q_m_wr_en, bus_error;
  logic [15:0] instr_m_data_in, data_m_data_in, dma_m_data_in, q_m_data_out;
  logic [18:0] q_m_addr;
  logic [1:0]  q_m_bytesel;

  logic        d4_instr_m_ack, d4_data_m_ack, d4_dma_m_ack, d4_q_m_access, d4_q_m_wr_en, d4_bus_error;
  logic [15:0] d4_instr_m_data_in, d4_data_m_data_in, d4_dma_m_data_in, d4_q_m_data_out;
  logic [18:0] d4_q_m_addr;
  logic [1:0]  d4_q_m_bytesel;

  int tests = 0;
  int fails = 0;

  rr_mem_arbiter #(.TIMEOUT_CYCLES(TO_MAIN)) dut (
    .clk(clk), .reset(reset),
    .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
    .instr_m_ack(instr_m_ack), .instr_m_data_in(instr_m_data_in),
    .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out),
    .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel), .data_m_ack(data_m_ack),
    .data_m_data_in(data_m_data_in),
    .dma_m_addr(dma_m_addr), .dma_m_data_out(dma_m_data_out),
    .dma_m_access(dma_m_access), .dma_m_wr_en(dma_m_wr_en),
    .dma_m_bytesel(dma_m_bytesel), .dma_m_ack(dma_m_ack),
    .dma_m_data_in(dma_m_data_in),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_access(q_m_access),
    .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel),
    .q_m_data_in(q_m_data_in), .q_m_ack(q_m_ack), .bus_error(bus_error)
  );

  rr_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset),
    .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
    .instr_m_ack(d4_instr_m_ack), .instr_m_data_in(d4_instr_m_data_in),
    .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out),
    .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel), .data_m_ack(d4_data_m_ack),
    .data_m_data_in(d4_data_m_data_in),
    .dma_m_addr(dma_m_addr), .dma_m_data_out(dma_m_data_out),
    .dma_m_access(dma_m_access), .dma_m_wr_en(dma_m_wr_en),
    .dma_m_bytesel(dma_m_bytesel), .dma_m_ack(d4_dma_m_ack),
    .dma_m_data_in(d4_dma_m_data_in),
    .q_m_addr(d4_q_m_addr), .q_m_data_out(d4_q_m_data_out), .q_m_access(d4_q_m_access),
    .q_m_wr_en(d4_q_m_wr_en), .q_m_bytesel(d4_q_m_bytesel),
    .q_m_data_in(q_m_data_in), .q_m_ack(q_m_ack), .bus_error(d4_bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_m_addr = '0; instr_m_access = 1'b0;
    data_m_addr = '0; data_m_data_out = '0; data_m_access = 1'b0;
    data_m_wr_en = 1'b0; data_m_bytesel = '0;
    dma_m_addr = '0; dma_m_data_out = '0; dma_m_access = 1'b0;
    dma_m_wr_en = 1'b0; dma_m_bytesel = '0;
    q_m_data_in = '0; q_m_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Transaction-level model: who owns the bus, how long it has waited,
  // whether the one-cycle gap is pending, and whose turn is next.
  initial begin : model
    int owner, waited, ptr, c;
    bit gap, done;
    logic [2:0]  req;
    logic [38:0] e_bus;
    logic [3:0]  e_ack;
    logic [47:0] e_rd;
    logic [15:0] rd;
    owner = -1; waited = 0; ptr = 0; gap = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_bus", {q_m_access, q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel}, '0);
        check("rst_acks", {instr_m_ack, data_m_ack, dma_m_ack, bus_error}, '0);
        owner = -1; waited = 0; ptr = 0; gap = 1'b0;
      end else begin
        req   = {dma_m_access, data_m_access, instr_m_access};
        e_bus = '0; e_ack = '0; e_rd = '0; done = 1'b0;
        rd    = q_m_ack ? q_m_data_in : 16'hffff;
        if (owner >= 0) begin
          done = q_m_ack || (waited == TO_MAIN - 1);
          if (owner == 0) begin
            e_bus = {1'b1, instr_m_addr, 16'h0000, 1'b0, 2'b11};
            if (done) begin e_ack[3] = 1'b1; e_rd[47:32] = rd; end
          end else if (owner == 1) begin
            e_bus = {1'b1, data_m_addr, data_m_data_out, data_m_wr_en, data_m_bytesel};
            if (done) begin e_ack[2] = 1'b1; e_rd[31:16] = rd; end
          end else begin
            e_bus = {1'b1, dma_m_addr, dma_m_data_out, dma_m_wr_en, dma_m_bytesel};
            if (done) begin e_ack[1] = 1'b1; e_rd[15:0] = rd; end
          end
          e_ack[0] = done && !q_m_ack;
        end
        check("model_bus", {q_m_access, q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel}, e_bus);
        check("model_acks", {instr_m_ack, data_m_ack, dma_m_ack, bus_error}, e_ack);
        check("model_rdata", {instr_m_data_in, data_m_data_in, dma_m_data_in}, e_rd);
        if (owner >= 0) begin
          if (done) begin
            ptr = (owner + 1) % 3; owner = -1; gap = 1'b1;
          end else begin
            waited++;
          end
        end else if (gap) begin
          gap = 1'b0;
        end else begin
          for (int k = 0; k < 3; k++) begin
            c = (ptr + k) % 3;
            if (owner < 0 && req[c]) begin owner = c; waited = 0; end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n, last_start, who;
    int exp_order [6] = '{0, 1, 2, 0, 1, 2};
    clear_inputs();
    #3;
    check("reset_access", q_m_access, 1'b0);
    check("reset_acks", {instr_m_ack, data_m_ack, dma_m_ack, bus_error}, 4'h0);

    // Single instruction read, slave answers in the third BUSY cycle.
    do_reset();
    instr_m_addr = 19'h7ff00; instr_m_access = 1'b1;
    #2; check("t1_idle_access", q_m_access, 1'b0);
    tick(); #2;
    check("t1_access_rise", q_m_access, 1'b1);
    check("t1_addr", q_m_addr, 19'h7ff00);
    check("t1_rd_attr", {q_m_wr_en, q_m_bytesel}, 3'b011);
    tick(); tick();
    q_m_ack = 1'b1; q_m_data_in = 16'h1234; #2;
    check("t1_ack", instr_m_ack, 1'b1);
    check("t1_rdata", instr_m_data_in, 16'h1234);
    instr_m_access = 1'b0;
    tick(); q_m_ack = 1'b0; q_m_data_in = '0; #2;
    check("t1_turn_access", q_m_access, 1'b0);
    check("t1_turn_ack", instr_m_ack, 1'b0);
    tick();

    // All three request continuously, slave acks in the first BUSY cycle.
    do_reset();
    instr_m_addr = 19'h00010; data_m_addr = 19'h00020; dma_m_addr = 19'h00030;
    instr_m_access = 1'b1; data_m_access = 1'b1; dma_m_access = 1'b1;
    n = 0; last_start = 0;
    for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
      tick();
      q_m_ack = q_m_access;
      q_m_data_in = q_m_access ? 16'h0a00 + 16'(n) : 16'h0000;
      #1;
      if (q_m_access) begin
        who = instr_m_ack ? 0 : data_m_ack ? 1 : dma_m_ack ? 2 : 3;
        check("rr_order", who, exp_order[n]);
        if (n > 0) check("rr_gap", cyc - last_start, 3);
        last_start = cyc;
        n++;
      end
    end
    check("rr_count", n, 6);
    instr_m_access = 1'b0; data_m_access = 1'b0; dma_m_access = 1'b0;
    tick(); q_m_ack = 1'b0; q_m_data_in = '0;
    tick();

    // Data write while instr waits; instr is served right after.
    do_reset();
    data_m_addr = 19'h12345; data_m_data_out = 16'hbeef; data_m_bytesel = 2'b01;
    data_m_wr_en = 1'b1; data_m_access = 1'b1;
    tick();
    instr_m_addr = 19'h00abc; instr_m_access = 1'b1; #2;
    check("t3_wr_bus", {q_m_access, q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel},
          {1'b1, 19'h12345, 16'hbeef, 1'b1, 2'b01});
    tick(); q_m_ack = 1'b1; #2;
    check("t3_wr_ack", {instr_m_ack, data_m_ack}, 2'b01);
    data_m_access = 1'b0; data_m_wr_en = 1'b0;
    tick(); q_m_ack = 1'b0; #2;
    check("t3_turn", q_m_access, 1'b0);
    tick(); #2;
    check("t3_idle", q_m_access, 1'b0);
    tick(); #2;
    check("t3_instr_bus", {q_m_access, q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel},
          {1'b1, 19'h00abc, 16'h0000, 1'b0, 2'b11});
    q_m_ack = 1'b1; q_m_data_in = 16'h4321; #1;
    check("t3_instr_ack", instr_m_data_in, 16'h4321);
    instr_m_access = 1'b0;
    tick(); q_m_ack = 1'b0; q_m_data_in = '0;
    tick();

    // DMA read with no slave ack: 8-cycle timeout, then a late ack.
    do_reset();
    dma_m_addr = 19'h05555; dma_m_access = 1'b1; q_m_data_in = 16'h5a5a;
    for (int k = 1; k <= 7; k++) begin
      tick(); #2;
      check("t4_wait_ack", dma_m_ack, 1'b0);
      check("t4_wait_err", bus_error, 1'b0);
      if (k == 4) begin
        check("t4_d4_timeout", {d4_dma_m_ack, d4_bus_error}, 2'b11);
        check("t4_d4_data", d4_dma_m_data_in, 16'hffff);
      end
    end
    tick(); #2;
    check("t4_to_ack", dma_m_ack, 1'b1);
    check("t4_to_data", dma_m_data_in, 16'hffff);
    check("t4_to_err", bus_error, 1'b1);
    dma_m_access = 1'b0;
    tick(); #2;
    check("t4_err_pulse", {q_m_access, bus_error}, 2'b00);
    tick(); q_m_ack = 1'b1; #2;
    check("t4_late_ack", {instr_m_ack, data_m_ack, dma_m_ack, bus_error}, 4'h0);
    tick(); q_m_ack = 1'b0; q_m_data_in = '0;
    tick();

    // TIMEOUT_CYCLES=4 instance: real ack in the 4th BUSY cycle beats the timeout.
    do_reset();
    dma_m_addr = 19'h40000; dma_m_access = 1'b1; q_m_data_in = 16'hc3c3;
    tick(); tick(); tick(); #2;
    check("t5_no_early_ack", {d4_dma_m_ack, d4_bus_error}, 2'b00);
    tick(); q_m_ack = 1'b1; #2;
    check("t5_ack", d4_dma_m_ack, 1'b1);
    check("t5_data", d4_dma_m_data_in, 16'hc3c3);
    check("t5_no_error", d4_bus_error, 1'b0);
    dma_m_access = 1'b0;
    tick(); q_m_ack = 1'b0; q_m_data_in = '0;
    tick();

    // Reset mid-BUSY with the pointer at dma; afterwards data beats dma.
    do_reset();
    data_m_addr = 19'h00100; data_m_access = 1'b1;
    tick(); q_m_ack = 1'b1; q_m_data_in = 16'h0001; #2;
    check("t6_pre_ack", data_m_ack, 1'b1);
    data_m_access = 1'b0;
    tick(); q_m_ack = 1'b0; q_m_data_in = '0;
    instr_m_addr = 19'h00200; instr_m_access = 1'b1;
    tick();
    tick(); #2;
    check("t6_busy", {q_m_access, q_m_addr}, {1'b1, 19'h00200});
    reset = 1'b1; #1;
    check("t6_async_access", q_m_access, 1'b0);
    check("t6_async_acks", {instr_m_ack, data_m_ack, dma_m_ack}, 3'b000);
    instr_m_access = 1'b0;
    tick(); tick();
    reset = 1'b0;
    data_m_access = 1'b1; dma_m_access = 1'b1; dma_m_addr = 19'h00300;
    tick(); #2;
    check("t6_grant_data", {q_m_access, q_m_addr}, {1'b1, 19'h00100});
    q_m_ack = 1'b1; #1;
    check("t6_data_ack", {data_m_ack, dma_m_ack}, 2'b10);
    data_m_access = 1'b0;
    tick(); q_m_ack = 1'b0; dma_m_access = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_mem_arbiter.md
Name: rr_mem_arbiter

Overview:
- Three-master round-robin arbiter that shares the single memory bus (SDRAM + BIOS) between the CPU instruction port, the CPU data port and a DMA/debug master.
- Sits between the Core and JTAG/DMA sources on one side and the address-decoded memory bus on the other.
- Holds each grant until the slave acks. Inserts one idle cycle between transfers. Optionally times out hung slaves.

Parameters:
- TIMEOUT_CYCLES, 0, cycles without slave ack before forced completion; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- instr_m_addr  in  19  instruction master word address [19:1]
- instr_m_access  in  1  instruction request
- instr_m_ack  out  1  instruction completion
- instr_m_data_in  out  16  read data to instruction master
- data_m_addr  in  19  data master address
- data_m_data_out  in  16  data master write data
- data_m_access  in  1  data request
- data_m_wr_en  in  1  data write
- data_m_bytesel  in  2  data byte enables
- data_m_ack  out  1  data completion
- data_m_data_in  out  16  read data to data master
- dma_m_addr, dma_m_data_out, dma_m_access, dma_m_wr_en, dma_m_bytesel  in  19/16/1/1/2  DMA master request; same meaning as the data-master inputs
- dma_m_ack  out  1  DMA completion
- dma_m_data_in  out  16  read data to DMA master
- q_m_addr  out  19  shared bus address
- q_m_data_out  out  16  shared bus write data
- q_m_access  out  1  shared bus request
- q_m_wr_en  out  1  shared bus write
- q_m_bytesel  out  2  shared bus byte enables
- q_m_data_in  in  16  shared bus read data, OR of slaves
- q_m_ack  in  1  shared bus completion
- bus_error  out  1  one-cycle pulse on timeout

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, round-robin pointer = instr, timeout counter = 0.
- Instruction master: read only. q_m_wr_en=0 and q_m_bytesel=2'b11 while it is granted.
- FSM states IDLE, BUSY, TURN.
- IDLE:
  - Sample the access inputs and pick the first requester at or after the pointer, in rotation instr -> data -> dma -> instr.
  - Register the grant (one-hot) and go to BUSY.
  - Latency: access rising in cycle t gives q_m_access=1 in cycle t+1.
- BUSY:
  - q_m_access=1.
  - q_m_addr, q_m_data_out, q_m_wr_en and q_m_bytesel are combinationally muxed from the granted master.
  - On q_m_ack: the granted master's ack=1 and its data_in=q_m_data_in in the same cycle. The pointer moves to the master after the granted one. Go to TURN.
- TURN: q_m_access=0 for exactly one cycle, then IDLE. This lets slaves see access fall and lets the completed master drop its request.
- Non-granted masters: ack=0 and data_in=0 at all times.
- Bus outputs when no grant is held: all 0.
- Timeout, when TIMEOUT_CYCLES>0:
  - The counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack: granted master ack=1, data_in=16'hffff, bus_error=1, advance the pointer, go to TURN.
  - If q_m_ack and timeout occur in the same cycle, the real ack wins and bus_error stays 0.
  - A late q_m_ack in TURN or IDLE is ignored; no master sees it.
- Master dropping access while granted: the grant is held regardless and the transfer completes normally.
- Reset asserted mid-transfer: q_m_access and all acks go to 0 immediately (asynchronous). The grant is dropped and the pointer returns to instr.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.

Decomposition:
- Shared package (mem_arb_pkg):
  - enum for the FSM states.
  - enum for master index: MASTER_INSTR=0, MASTER_DATA=1, MASTER_DMA=2.
  - Constant TIMEOUT_DATA = 16'hffff.
- One natural sub-module: rr_priority_pick. It is purely combinational: takes a 3-bit request vector and the pointer, and returns a one-hot grant.
- FSM, counter and muxes live in rr_mem_arbiter.

Test Plan:
- Single instr read at addr 19'h7ff00; slave acks 2 cycles later with data 16'h1234:
  - q_m_access rises 1 cycle after request.
  - instr_m_ack=1 with instr_m_data_in=16'h1234.
  - q_m_access=0 in the following cycle.
- All three masters request continuously, each slave response taking 1 cycle:
  - Grant order is instr, data, dma, instr, ….
  - Exactly one TURN cycle separates transfers.
  - No master is granted twice in a row while others wait.
- Data write of 16'hbeef, bytesel=2'b01, while instr is also requesting:
  - q_m_wr_en=1, q_m_bytesel=2'b01, q_m_data_out=16'hbeef during the data grant.
  - The instr request stays pending and is served next.
- TIMEOUT_CYCLES=8, DMA read with no slave ack:
  - On the 8th BUSY cycle: dma_m_ack=1, dma_m_data_in=16'hffff, bus_error pulses for 1 cycle.
  - A late q_m_ack two cycles later produces no master ack.
- Ack and timeout in the same cycle (TIMEOUT_CYCLES=4, ack on 4th BUSY cycle): master receives the slave data and bus_error=0.
- Reset asserted mid-BUSY:
  - q_m_access=0 without waiting for a clock edge.
  - After release, a simultaneous data+dma request is granted to data (pointer back at instr, data first in rotation).
